spi3w_reg_target: RTL

SPI3W_REG_TARGET -- requirements
Module: spi3w_reg_target

---
 rtl/spi3w_reg_target.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi3w_reg_target.sv
// spi3w_reg_target: 3-wire SPI configuration target with an 8-bit register file.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no frame; waiting for a fresh spi_ce fall
// ST_INSTR   | shifting in the 16-bit instruction
// ST_WR_DATA | shifting in write bytes, committing each completed byte
// ST_RD_DATA | driving read bytes MSB first on spi_io_out
// ST_HOLD    | byte count exhausted; ignore spi_clk until spi_ce rises
module spi3w_reg_target #(
  parameter int         ADDR_W  = 6,
  parameter logic [7:0] CHIP_ID = 8'hA5
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              spi_ce,
  input  logic              spi_clk,
  input  logic              spi_io_in,
  output logic              spi_io_out,
  output logic              spi_io_oe,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INSTR, ST_WR_DATA, ST_RD_DATA, ST_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              ce_s1_q, ce_s1_d, ce_s2_q, ce_s2_d;
  logic              sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_s3_q, sclk_s3_d;
  logic              io_s1_q, io_s1_d, io_s2_q, io_s2_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              stream_q, stream_d;
  logic [12:0]       addr_q, addr_d;
  logic [14:0]       sh_q, sh_d;
  logic [6:0]        out_sh_q, out_sh_d;
  logic              load_q, load_d;
  logic              oe_q, oe_d;
  logic              io_out_q, io_out_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;
  logic [7:0]        mem_q [NREG];
  logic [7:0]        mem_d [NREG];

  logic              sclk_rise, sclk_fall, in_range, addr_ok, byte_end;
  logic [15:0]       sh_nxt;
  logic [ADDR_W-1:0] addr_idx;
  logic [7:0]        rd_val;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign sh_nxt    = {sh_q, io_s2_q};
  assign addr_idx  = addr_q[ADDR_W-1:0];
  assign in_range  = ((addr_q >> ADDR_W) == 13'd0);
  assign addr_ok   = in_range && (addr_q != 13'd0);
  assign rd_val    = (addr_q == 13'd0) ? CHIP_ID : (in_range ? mem_q[addr_idx] : 8'h00);

  // Host read port: register 0 is the hard-wired chip ID.
  always_comb begin
    host_data = (host_addr == '0) ? CHIP_ID : mem_q[host_addr];
  end

  // Next-state logic for the synchronizers, frame FSM, shifters and register file.
  always_comb begin
    ce_s1_d     = spi_ce;
    ce_s2_d     = ce_s1_q;
    sclk_s1_d   = spi_clk;
    sclk_s2_d   = sclk_s1_q;
    sclk_s3_d   = sclk_s2_q;
    io_s1_d     = spi_io_in;
    io_s2_d     = io_s1_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    stream_d    = stream_q;
    addr_d      = addr_q;
    sh_d        = sh_q;
    out_sh_d    = out_sh_q;
    load_d      = load_q;
    oe_d        = oe_q;
    io_out_d    = io_out_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = err_q;
    settle_d    = settle_q;
    armed_d     = armed_q;
    mem_d       = mem_q;
    byte_end    = 1'b0;

    // The synchronizers hold reset levels for two cycles; only arm frame start
    // once spi_ce has genuinely been seen high, so a low spi_ce after reset is ignored.
    if (settle_q != 2'd0) settle_d = settle_q - 2'd1;
    else if (ce_s2_q)     armed_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !ce_s2_q) begin
          state_d   = ST_INSTR;
          bit_cnt_d = 4'd15;
          armed_d   = 1'b0;
        end
      end
      ST_INSTR: begin
        if (sclk_rise) begin
          sh_d      = sh_nxt[14:0];
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            addr_d     = sh_nxt[12:0];
            byte_cnt_d = sh_nxt[14:13];
            stream_d   = &sh_nxt[14:13];
            bit_cnt_d  = 4'd7;
            load_d     = 1'b1;
            state_d    = sh_nxt[15] ? ST_RD_DATA : ST_WR_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (sclk_rise) begin
          sh_d      = sh_nxt[14:0];
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            byte_end = 1'b1;
            if (addr_ok) begin
              mem_d[addr_idx] = sh_nxt[7:0];
              wr_strobe_d     = 1'b1;
              wr_addr_d       = addr_idx;
              wr_data_d       = sh_nxt[7:0];
            end
          end
        end
      end
      ST_RD_DATA: begin
        if (sclk_fall) begin
          oe_d = 1'b1;
          if (load_q) begin
            io_out_d = rd_val[7];
            out_sh_d = rd_val[6:0];
            load_d   = 1'b0;
          end else begin
            io_out_d = out_sh_q[6];
            out_sh_d = {out_sh_q[5:0], 1'b0};
          end
        end
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q - 4'd1;
          if (bit_cnt_q == 4'd0) begin
            byte_end = 1'b1;
            load_d   = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    if (byte_end) begin
      addr_d    = addr_q - 13'd1;
      bit_cnt_d = 4'd7;
      if (!stream_q) begin
        if (byte_cnt_q == 2'd0) state_d = ST_HOLD;
        else                    byte_cnt_d = byte_cnt_q - 2'd1;
      end
    end

    // spi_ce rise ends any frame; a byte completing this cycle is already committed above.
    if ((state_q != ST_IDLE) && ce_s2_q) begin
      if (((state_d == ST_INSTR) && (bit_cnt_d != 4'd15)) ||
          (((state_d == ST_WR_DATA) || (state_d == ST_RD_DATA)) && (bit_cnt_d != 4'd7)))
        err_d = 1'b1;
      state_d = ST_IDLE;
    end

    if (state_d != ST_RD_DATA) begin
      oe_d     = 1'b0;
      io_out_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State register with synchronous reset; synchronizers reset to idle pin levels.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      ce_s1_q     <= 1'b1;
      ce_s2_q     <= 1'b1;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      io_s1_q     <= 1'b0;
      io_s2_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      byte_cnt_q  <= 2'd0;
      stream_q    <= 1'b0;
      addr_q      <= 13'd0;
      sh_q        <= 15'd0;
      out_sh_q    <= 7'd0;
      load_q      <= 1'b0;
      oe_q        <= 1'b0;
      io_out_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      settle_q    <= 2'd2;
      armed_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) mem_q[i] <= 8'h00;
    end else begin
      ce_s1_q     <= ce_s1_d;
      ce_s2_q     <= ce_s2_d;
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_s3_q   <= sclk_s3_d;
      io_s1_q     <= io_s1_d;
      io_s2_q     <= io_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      stream_q    <= stream_d;
      addr_q      <= addr_d;
      sh_q        <= sh_d;
      out_sh_q    <= out_sh_d;
      load_q      <= load_d;
      oe_q        <= oe_d;
      io_out_q    <= io_out_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      mem_q       <= mem_d;
    end
  end

  assign spi_io_out = io_out_q;
  assign spi_io_oe  = oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_err  = err_q;

endmodule
